// File: rtl/fetch_pkg.sv
// fetch_pkg: shared queue entry type, fetch reset constants and ring-pointer helper.
package fetch_pkg;
  localparam int FETCH_XLEN = 32;
  localparam logic [FETCH_XLEN-1:0] FETCH_NOP_INSTR = 32'h0000_0000;
  localparam logic [FETCH_XLEN-1:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] instr;
    logic [FETCH_XLEN-1:0] pcplus4;
  } fetch_entry_t;

  // depth is a power of two, so wrapping is a mask rather than a modulo
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1) & (depth - 1);
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry ring FIFO of fetch entries; flush empties it, push and pop may coincide when full.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic [CW-1:0] count
);
  fetch_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;

  assign rdata = r_mem[r_head];
  assign count = r_count;
  assign full  = r_count == CW'(DEPTH);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      if (push) r_tail <= AW'(next_ptr(32'(r_tail), DEPTH));
      if (pop) r_head <= AW'(next_ptr(32'(r_head), DEPTH));
      r_count <= r_count + CW'(push) - CW'(pop);
    end

  always_ff @(posedge clk)
    if (push && !flush) r_mem[r_tail] <= wdata;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, sequential/redirect next-PC select and decode-side instruction queue.
// Defining FETCH_ALIGN_CHECK_EN force-aligns redirect targets and flags misaligned ones in misalign_err.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int XLEN = FETCH_XLEN,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = FETCH_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = FETCH_NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [XLEN-1:0]        imem_addr,
  input  logic [XLEN-1:0]        imem_rdata,
  input  logic                   stall_f,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic [XLEN-1:0]        instr_d,
  output logic [XLEN-1:0]        pcplus4_d,
  output logic                   valid_d,
  input  logic                   ready_d,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   misalign_err
);
  logic [XLEN-1:0] r_pc, w_pcplus4, w_redirect_pc;
  logic w_push, w_pop, w_full;
  fetch_entry_t w_head;

  assign imem_addr = r_pc;
  assign w_pcplus4 = r_pc + XLEN'(4);
  assign valid_d   = occupancy != '0;
  assign w_pop     = valid_d & ready_d;
  assign w_push    = !redirect_valid & !stall_f & (!w_full | w_pop);
  assign instr_d   = valid_d ? w_head.instr : NOP_INSTR;
  assign pcplus4_d = valid_d ? w_head.pcplus4 : '0;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_misalign;
  assign w_redirect_pc = {redirect_pc[XLEN-1:2], 2'b00};
  assign misalign_err  = r_misalign;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_misalign <= 1'b0;
    else if (redirect_valid && redirect_pc[1:0] != 2'b00) r_misalign <= 1'b1;
`else
  assign w_redirect_pc = redirect_pc;
  assign misalign_err  = 1'b0;
`endif

  // redirect outranks both stall and a full queue
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_pc <= RESET_PC;
    else if (redirect_valid) r_pc <= w_redirect_pc;
    else if (w_push) r_pc <= w_pcplus4;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect_valid),
    .wdata ('{instr: imem_rdata, pcplus4: w_pcplus4}),
    .rdata (w_head),
    .full  (w_full),
    .count (occupancy)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a queue-based reference model.
module tb_fetch_stage;
  localparam int DEPTH = 4;
  localparam logic [31:0] TAG = 32'hA000_0000;

  logic clk = 0, rst_n = 0;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr_d, pcplus4_d;
  logic stall_f = 0, redirect_valid = 0, ready_d = 0, valid_d, misalign_err;
  logic [2:0] occupancy;
  int checks = 0, errors = 0;

  logic [63:0] mq[$];
  logic [31:0] m_pc;
  bit m_mis;

  assign imem_rdata = imem_addr | TAG;
  always #5 clk = ~clk;

  fetch_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall_f(stall_f), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_d(instr_d), .pcplus4_d(pcplus4_d), .valid_d(valid_d), .ready_d(ready_d),
    .occupancy(occupancy), .misalign_err(misalign_err)
  );

  function automatic logic [31:0] exp_instr();
    return mq.size() != 0 ? mq[0][63:32] : 32'h0;
  endfunction
  function automatic logic [31:0] exp_pc4();
    return mq.size() != 0 ? mq[0][31:0] : 32'h0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc = 32'h0;
    m_mis = 0;
  endtask

  // one clock edge; the model applies the architectural rules to its own queue
  task automatic tick();
    bit pop, push;
    logic [63:0] ent;
    pop = mq.size() != 0 && ready_d;
    push = !redirect_valid && !stall_f && (mq.size() < DEPTH || pop);
    ent = {m_pc | TAG, m_pc + 32'd4};
    @(posedge clk);
    #1;
    if (pop) void'(mq.pop_front());
    if (redirect_valid) begin
      mq.delete();
`ifdef FETCH_ALIGN_CHECK_EN
      m_pc = redirect_pc & ~32'd3;
      if (redirect_pc[1:0] != 2'b00) m_mis = 1;
`else
      m_pc = redirect_pc;
`endif
    end else if (push) begin
      mq.push_back(ent);
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic set_in(input bit st, input bit rv, input logic [31:0] rp, input bit rd);
    stall_f = st;
    redirect_valid = rv;
    redirect_pc = rp;
    ready_d = rd;
  endtask

  task automatic pulse_reset();
    rst_n = 0;
    #2;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (imem_addr !== 32'h0 || valid_d !== 1'b0 || instr_d !== 32'h0 || pcplus4_d !== 32'h0 ||
        occupancy !== 3'd0 || misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: addr=%h valid=%b instr=%h pc4=%h occ=%0d mis=%b required 0 0 0 0 0 0",
               imem_addr, valid_d, instr_d, pcplus4_d, occupancy, misalign_err);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_free_run();
    logic [31:0] ei[2] = '{32'hA000_0000, 32'hA000_0004};
    logic [31:0] ep[2] = '{32'h4, 32'h8};
    set_in(0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (instr_d !== ei[i] || pcplus4_d !== ep[i] || valid_d !== 1'b1) begin
        errors++;
        $display("FAIL free_run%0d: instr=%h pc4=%h valid=%b required %h %h 1",
                 i, instr_d, pcplus4_d, valid_d, ei[i], ep[i]);
      end
      checks++;
      if (imem_addr !== 32'(4 * (i + 1))) begin
        errors++;
        $display("FAIL free_run_addr%0d: addr=%h required %h", i, imem_addr, 32'(4 * (i + 1)));
      end
    end
  endtask

  task automatic test_backpressure();
    pulse_reset();
    set_in(0, 0, 0, 0);
    repeat (6) tick();
    checks++;
    if (occupancy !== 3'd4 || imem_addr !== 32'h10 || valid_d !== 1'b1 || instr_d !== 32'hA000_0000) begin
      errors++;
      $display("FAIL full_hold: occ=%0d addr=%h valid=%b instr=%h required 4 00000010 1 a0000000",
               occupancy, imem_addr, valid_d, instr_d);
    end
    set_in(0, 0, 0, 1);
    tick();
    checks++;
    if (occupancy !== 3'd4 || imem_addr !== 32'h14 || instr_d !== 32'hA000_0004) begin
      errors++;
      $display("FAIL full_pop_push: occ=%0d addr=%h instr=%h required 4 00000014 a0000004",
               occupancy, imem_addr, instr_d);
    end
  endtask

  task automatic test_redirect();
    set_in(1, 0, 0, 1);
    tick();
    checks++;
    if (occupancy !== 3'd3) begin
      errors++;
      $display("FAIL redirect_setup: occ=%0d required 3", occupancy);
    end
    set_in(1, 1, 32'h100, 0);
    tick();
    checks++;
    if (occupancy !== 3'd0 || valid_d !== 1'b0 || imem_addr !== 32'h100 || instr_d !== 32'h0) begin
      errors++;
      $display("FAIL redirect_flush: occ=%0d valid=%b addr=%h instr=%h required 0 0 00000100 0",
               occupancy, valid_d, imem_addr, instr_d);
    end
    set_in(0, 0, 0, 0);
    tick();
    checks++;
    if (instr_d !== 32'hA000_0100 || pcplus4_d !== 32'h104 || valid_d !== 1'b1) begin
      errors++;
      $display("FAIL redirect_first: instr=%h pc4=%h valid=%b required a0000100 00000104 1",
               instr_d, pcplus4_d, valid_d);
    end
  endtask

  task automatic test_stall_empty();
    logic [31:0] held;
    set_in(1, 0, 0, 1);
    tick();
    held = imem_addr;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (imem_addr !== held || valid_d !== 1'b0 || instr_d !== 32'h0 || occupancy !== 3'd0) begin
        errors++;
        $display("FAIL stall%0d: addr=%h valid=%b instr=%h occ=%0d required %h 0 0 0",
                 i, imem_addr, valid_d, instr_d, occupancy, held);
      end
    end
    set_in(0, 0, 0, 0);
    tick();
    checks++;
    if (instr_d !== (held | TAG) || pcplus4_d !== held + 32'd4 || imem_addr !== held + 32'd4) begin
      errors++;
      $display("FAIL stall_resume: instr=%h pc4=%h addr=%h required %h %h %h",
               instr_d, pcplus4_d, imem_addr, held | TAG, held + 32'd4, held + 32'd4);
    end
  endtask

  task automatic test_wrap();
    set_in(0, 1, 32'hFFFF_FFFC, 1);
    tick();
    set_in(0, 0, 0, 0);
    tick();
    checks++;
    if (pcplus4_d !== 32'h0 || instr_d !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap: pc4=%h instr=%h addr=%h required 0 fffffffc 0", pcplus4_d, instr_d, imem_addr);
    end
  endtask

  task automatic test_misalign();
    set_in(0, 1, 32'h102, 0);
    tick();
    set_in(0, 0, 0, 1);
`ifdef FETCH_ALIGN_CHECK_EN
    checks++;
    if (imem_addr !== 32'h100 || misalign_err !== 1'b1) begin
      errors++;
      $display("FAIL misalign_set: addr=%h mis=%b required 00000100 1", imem_addr, misalign_err);
    end
    repeat (3) tick();
    checks++;
    if (misalign_err !== 1'b1) begin
      errors++;
      $display("FAIL misalign_sticky: mis=%b required 1", misalign_err);
    end
    pulse_reset();
    checks++;
    if (misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL misalign_clear: mis=%b required 0", misalign_err);
    end
`else
    checks++;
    if (imem_addr !== 32'h102 || misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL misalign_off: addr=%h mis=%b required 00000102 0", imem_addr, misalign_err);
    end
    pulse_reset();
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(3) == 0, $urandom_range(15) == 0,
             $urandom_range(7) == 0 ? $urandom : ($urandom & 32'hFFFF_FFFC), $urandom_range(1) == 1);
      tick();
      checks++;
      if (imem_addr !== m_pc || occupancy !== 3'(mq.size()) || valid_d !== (mq.size() != 0) ||
          instr_d !== exp_instr() || pcplus4_d !== exp_pc4() || misalign_err !== m_mis) begin
        errors++;
        $display("FAIL random%0d: addr=%h occ=%0d valid=%b instr=%h pc4=%h mis=%b required %h %0d %b %h %h %b",
                 i, imem_addr, occupancy, valid_d, instr_d, pcplus4_d, misalign_err,
                 m_pc, mq.size(), mq.size() != 0, exp_instr(), exp_pc4(), m_mis);
      end
    end
  endtask

  task automatic test_async_reset();
    set_in(0, 0, 0, 0);
    repeat (3) tick();
    #2;
    rst_n = 0;
    #1;
    model_reset();
    checks++;
    if (imem_addr !== 32'h0 || valid_d !== 1'b0 || instr_d !== 32'h0 || pcplus4_d !== 32'h0 ||
        occupancy !== 3'd0 || misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: addr=%h valid=%b instr=%h pc4=%h occ=%0d mis=%b required 0 0 0 0 0 0",
               imem_addr, valid_d, instr_d, pcplus4_d, occupancy, misalign_err);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_free_run();
    test_backpressure();
    test_redirect();
    test_stall_empty();
    test_wrap();
    test_misalign();
    test_random();
    test_async_reset();
    test_free_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Parametrised instruction-fetch stage that generalises the fixed PC mux / PC+4 / IF-ID latch path into one block.
- Owns the PC register, next-PC selection (sequential or redirect) and the instruction-memory address.
- Decouples fetch from decode with a DEPTH-entry instruction queue carrying {instr, pcplus4}; decode consumes it through a valid/ready handshake.
- Sits between instructionMemory and the decode stage; stall_f comes from hazardUnit, redirects come from branch/jump resolution.

Parameters:
XLEN, 32, width of PC and instruction words
DEPTH, 4, instruction-queue entries; power of 2, at least 2
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction presented on instr_d when the queue is empty

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
imem_addr  output  XLEN  current PC, driven to instruction memory
imem_rdata  input  XLEN  instruction at imem_addr, combinational same-cycle read
stall_f  input  1  hazard-unit fetch stall; when high, the PC holds and nothing is pushed
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  XLEN  redirect target
instr_d  output  XLEN  head-of-queue instruction to decode
pcplus4_d  output  XLEN  head-of-queue PC+4
valid_d  output  1  queue non-empty
ready_d  input  1  decode accepts the head this cycle (the !stallD equivalent)
occupancy  output  $clog2(DEPTH)+1  current queue count
misalign_err  output  1  sticky misaligned-redirect flag (see Optional Feature)

Behaviour:
Reset (async, rst_n=0):
- pc=RESET_PC; queue emptied (head=tail=count=0).
- valid_d=0, instr_d=NOP_INSTR, pcplus4_d=0, occupancy=0, misalign_err=0.
- Reset asserted mid-operation discards all queued entries immediately.

Signal definitions:
- imem_addr = pc, combinational from the register.
- pcplus4 = pc + 4, modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
- pop = valid_d & ready_d.
- push = !redirect_valid & !stall_f & (count<DEPTH | pop). A full queue accepts a push in the same cycle as a pop.

On push:
- Entry {imem_rdata, pcplus4} is written at tail; tail increments modulo DEPTH.
- pc <= pcplus4.

On pop:
- head increments modulo DEPTH.

count update:
- count <= count + push - pop.

PC when not pushing:
- pc holds when stall_f=1, or when the queue is full with no pop. This is back-pressure, not an error.

Redirect (highest priority; overrides stall_f and a full queue):
- pc <= redirect_pc.
- All queue entries are invalidated: head=tail, count=0.
- push is suppressed; a pop in the same cycle is still honoured for the current head, which decode already holds.
- Next cycle: valid_d=0; the first redirected instruction becomes visible at decode one cycle after that.

Latency:
- Instruction fetched in cycle N is visible on instr_d/valid_d in cycle N+1 if the queue was empty. The queue is registered; there is no combinational bypass from imem_rdata to instr_d.

Outputs:
- When valid_d=0: instr_d=NOP_INSTR, pcplus4_d=0.
- valid_d = (count!=0); occupancy = count.

Handshake rule:
- Decode may hold ready_d low indefinitely; head and its outputs stay stable until popped or redirected.

Optional Feature:
Macro FETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 sets misalign_err=1 (sticky until reset).
  - pc loads {redirect_pc[XLEN-1:2],2'b00}.
- Undefined:
  - misalign_err tied to 0.
  - pc loads redirect_pc unmodified.

Decomposition:
- Package fetch_pkg:
  - typedef fetch_entry_t {instr, pcplus4}, both XLEN.
  - Constants FETCH_NOP_INSTR and FETCH_RESET_PC.
  - Function next_ptr (modulo-DEPTH increment).
- One sub-module fetch_queue:
  - Parametrised DEPTH FIFO of fetch_entry_t.
  - Ports push, pop, flush, full, count.
  - Simultaneous push and pop when full is allowed.
- PC register and next-PC logic stay in fetch_stage.

Test Plan:
- Reset then free-run, ready_d=1, imem returns addr|32'hA000_0000 -> imem_addr 0,4,8,...; instr_d=A000_0000 with pcplus4_d=4 in cycle 1, then A000_0004 with pcplus4_d=8 in cycle 2.
- ready_d=0 for 6 cycles, DEPTH=4 -> occupancy reaches 4, imem_addr freezes at 0x10, valid_d=1, instr_d stays A000_0000.
- Queue full, then ready_d=1 for one cycle -> same-cycle pop and push, occupancy stays 4, imem_addr advances to 0x14.
- redirect_valid=1, redirect_pc=0x100, with stall_f=1 and queue at 3 -> next cycle occupancy=0, valid_d=0, imem_addr=0x100; following cycle instr_d=A000_0100, pcplus4_d=0x104.
- stall_f=1 for 3 cycles, queue empty, ready_d=1 -> imem_addr constant, valid_d=0, instr_d=NOP_INSTR; resumes at the same PC.
- FETCH_ALIGN_CHECK_EN defined, redirect_pc=0x102 -> imem_addr=0x100, misalign_err=1 until rst_n pulses low; rst_n low mid-run -> all outputs at reset values asynchronously.
